// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional encoder / Viterbi pair.
// Generator polynomials are common to encoder and decoder.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    DONE
  } enc_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Shift register plus generator XORs of the rate-1/2 encoder.
// sr_q[K-2] is the most recent bit (s1), sr_q[0] the oldest (s2).
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         bit_i,
  output logic [1:0]   sym_o,
  output logic [K-2:0] state_o
);

  logic [K-2:0] sr_q, sr_d;
  logic [K-1:0] win;

  assign win     = {bit_i, sr_q};
  assign sym_o   = {^(win & G0), ^(win & G1)};
  assign state_o = sr_q;

  // clear wins over load; otherwise hold
  always_comb begin
    sr_d = sr_q;
    if (clear)
      sr_d = '0;
    else if (load)
      sr_d = win[K-1:1];
  end

  // shift register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sr_q <= '0;
    else
      sr_q <= sr_d;
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with frame FSM.
// CONV_ENC_TAIL_EN: append K-1 zero tail bits per frame.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int K         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       din_valid,
  input  logic       din,
  output logic       din_ready,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       sym_last,
  output logic       busy,
  output logic       done
);

  localparam int CW = cnt_w(FRAME_LEN);

  enc_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sym_q, sym_d;
  logic            sym_valid_q, sym_valid_d;
  logic            sym_last_q, sym_last_d;
  logic            done_q, done_d;
`ifdef CONV_ENC_TAIL_EN
  localparam int TW = $clog2(K);
  logic [TW-1:0]   tail_q, tail_d;
`endif

  logic            core_load;
  logic            core_clear;
  logic            core_bit;
  logic [1:0]      core_sym;
  logic [K-2:0]    unused_core_state;

  conv_enc_core #(
    .K(K)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .clear  (core_clear),
    .bit_i  (core_bit),
    .sym_o  (core_sym),
    .state_o(unused_core_state)
  );

  assign din_ready = (state_q == DATA);
  assign busy      = (state_q != IDLE);
  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign sym_last  = sym_last_q;
  assign done      = done_q;

  // frame FSM next state; en=0 holds every register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    done_d      = done_q;
`ifdef CONV_ENC_TAIL_EN
    tail_d      = tail_q;
`endif
    core_load   = 1'b0;
    core_clear  = 1'b0;
    core_bit    = din;
    if (en) begin
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = DATA;
            cnt_d      = '0;
            core_clear = 1'b1;
          end
        end
        DATA: begin
          if (din_valid) begin
            core_load   = 1'b1;
            sym_d       = core_sym;
            sym_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
`ifdef CONV_ENC_TAIL_EN
              state_d = TAIL;
              tail_d  = '0;
`else
              sym_last_d = 1'b1;
              state_d    = DONE;
`endif
            end
          end
        end
`ifdef CONV_ENC_TAIL_EN
        TAIL: begin
          core_bit    = 1'b0;
          core_load   = 1'b1;
          sym_d       = core_sym;
          sym_valid_d = 1'b1;
          if (tail_q == TW'(K - 2)) begin
            sym_last_d = 1'b1;
            state_d    = DONE;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
`endif
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      done_q      <= done_d;
`ifdef CONV_ENC_TAIL_EN
      tail_q      <= tail_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder with a symbol scoreboard.
// Expectations follow CONV_ENC_TAIL_EN the same way the design does.
module tb_conv_encoder;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       din_ready;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_q[$];
  logic       m_s1, m_s2;
  int         m_cnt;
  logic       prev_last = 1'b0;

  conv_encoder #(
    .FRAME_LEN(FL),
    .K        (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .din_valid(din_valid),
    .din      (din),
    .din_ready(din_ready),
    .sym_valid(sym_valid),
    .sym      (sym),
    .sym_last (sym_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic b, input logic s1,
                                     input logic s2);
    return {b ^ s1 ^ s2, b ^ s2};
  endfunction

  task automatic push_bit(input logic b, input logic last);
    exp_q.push_back({enc(b, m_s1, m_s2), last});
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  // scoreboard: push on accept, pop on every consumed symbol
  always @(negedge clk) begin
    if (rst && en) begin
      if (sym_valid) begin
        if (exp_q.size() == 0)
          chk("sym_unexpected", 8'(sym_valid), 8'd0);
        else
          chk("sym", {5'd0, sym, sym_last}, {5'd0, exp_q.pop_front()});
      end
      if (done)
        chk("done_after_last", 8'(prev_last), 8'd1);
      prev_last = sym_valid && sym_last;
      if (!busy && start) begin
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_cnt = 0;
      end
      if (din_valid && din_ready) begin
`ifdef CONV_ENC_TAIL_EN
        push_bit(din, 1'b0);
        m_cnt++;
        if (m_cnt == FL) begin
          push_bit(1'b0, 1'b0);
          push_bit(1'b0, 1'b1);
        end
`else
        push_bit(din, m_cnt == FL - 1);
        m_cnt++;
`endif
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_din_ready"}, 8'(din_ready), 8'd0);
    chk({tag, "_sym_valid"}, 8'(sym_valid), 8'd0);
    chk({tag, "_sym"}, 8'(sym), 8'd0);
    chk({tag, "_sym_last"}, 8'(sym_last), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
  endtask

  task automatic wait_done(input string tag);
    int got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      @(negedge clk);
      if (done && en) got = 1;
    end
    chk({tag, "_done_seen"}, 8'(got), 8'd1);
    chk({tag, "_queue_empty"}, 8'(exp_q.size()), 8'd0);
    @(posedge clk) #1;
  endtask

  task automatic feed(input string tag, input logic [FL-1:0] bits,
                      input bit do_start, input bit gaps,
                      input bit freeze, input bit mid_start);
    int i = 0;
    int cyc = 0;
    if (do_start) begin
      @(posedge clk) #1 start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
    end
    while (i < FL && cyc < 200) begin
      din       = bits[FL-1-i];
      din_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      en        = !(freeze && cyc >= 3 && cyc < 6);
      start     = mid_start && cyc == 2;
      @(negedge clk);
      if (din_valid && din_ready && en) i++;
      @(posedge clk) #1;
      cyc++;
    end
    start     = 1'b0;
    din_valid = 1'b0;
    en        = 1'b1;
    chk({tag, "_accepts"}, 8'(i), 8'(FL));
    wait_done(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    @(posedge clk) #1 rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk);
    chk("start_din_ready", 8'(din_ready), 8'd1);
    chk("start_busy", 8'(busy), 8'd1);
    @(posedge clk) #1;

    feed("f10110000", 8'b1011_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    feed("ones", 8'b1111_1111, 1'b1, 1'b0, 1'b0, 1'b0);
    feed("gaps", 8'b1011_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    feed("freeze", 8'b1011_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    feed("mid_start", 8'b1100_1010, 1'b1, 1'b0, 1'b0, 1'b1);

    // abort a frame after four accepted bits
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    din_valid = 1'b1;
    din       = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      @(posedge clk) #1;
    end
    rst = 1'b0;
    #1;
    check_idle("abort");
    exp_q.delete();
    prev_last = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    feed("restart", 8'b1011_0000, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
